// File: rtl/bmp_pixel_reader_if.sv
// bmp_pixel_reader_if
// Groups the frame-control, byte-memory and pixel-output signals of the
// BMP pixel reader into one bundle.
//
// Parameters:
//   WIDTH      bits per colour channel and per memory byte
//   ADDR_BITS  memory byte-address width
//
// Signals:
//   start          frame start request (sampled only while the reader is idle)
//   pix_base       byte address of the first pixel byte, sampled with start
//   mem_addr       memory read address
//   mem_rd_en      memory read enable
//   mem_rd_data    memory read data, valid the cycle after mem_rd_en
//   r/g/b_data_out pixel channels
//   data_out_done  one-cycle strobe: pixel channels valid
//   busy           frame in progress
//   frame_done     one-cycle pulse together with the last pixel of a frame
//
// Modports:
//   master  the reader itself
//   slave   the environment (frame memory, filter, controller)
interface bmp_pixel_reader_if #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 20
);
  logic                 start;
  logic [ADDR_BITS-1:0] pix_base;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_rd_en;
  logic [WIDTH-1:0]     mem_rd_data;
  logic [WIDTH-1:0]     r_data_out;
  logic [WIDTH-1:0]     g_data_out;
  logic [WIDTH-1:0]     b_data_out;
  logic                 data_out_done;
  logic                 busy;
  logic                 frame_done;

  modport master (
    input  start, pix_base, mem_rd_data,
    output mem_addr, mem_rd_en,
    output r_data_out, g_data_out, b_data_out,
    output data_out_done, busy, frame_done
  );

  modport slave (
    output start, pix_base, mem_rd_data,
    input  mem_addr, mem_rd_en,
    input  r_data_out, g_data_out, b_data_out,
    input  data_out_done, busy, frame_done
  );
endinterface

// File: rtl/bmp_pixel_reader.sv
// bmp_pixel_reader
// Streams a 24-bit BMP pixel array (bytes in B,G,R order) out of a byte-wide
// synchronous memory and presents one RGB pixel per data_out_done strobe,
// ready to feed the sharpening filter input.
//
// A frame is ROWS x COLS pixels read strictly in memory order starting at
// pix_base. One byte is read per cycle with no bubbles, so the steady-state
// output rate is one pixel every three cycles. The first strobe appears five
// cycles after start is accepted.
//
// Parameters:
//   WIDTH      bits per colour channel and per memory byte
//   ROWS       pixel rows per frame
//   COLS       pixels per row
//   ADDR_BITS  memory byte-address width (address arithmetic wraps)
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset; aborts a frame immediately
//   bus    bmp_pixel_reader_if.master (start/pix_base, memory read port,
//          pixel outputs, busy, frame_done)
//
// Optional feature macro:
//   BMP_PIXEL_READER_PAD_EN  when defined, each row is padded to a multiple
//                            of 4 bytes and the pad bytes are skipped in the
//                            same cycle as the row-end address step. When
//                            undefined, rows are assumed tightly packed
//                            (valid when COLS*3 is a multiple of 4).
module bmp_pixel_reader #(
  parameter int WIDTH     = 8,
  parameter int ROWS      = 512,
  parameter int COLS      = 512,
  parameter int ADDR_BITS = 20
) (
  input logic                clk,
  input logic                reset,
  bmp_pixel_reader_if.master bus
);

  localparam int COL_BITS = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_BITS = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [COL_BITS-1:0]  LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0]  LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0]  COL_ONE  = COL_BITS'(1);
  localparam logic [ROW_BITS-1:0]  ROW_ONE  = ROW_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  // Byte phase within a pixel, following the BMP byte order.
  localparam logic [1:0] PHASE_B = 2'd0;
  localparam logic [1:0] PHASE_G = 2'd1;
  localparam logic [1:0] PHASE_R = 2'd2;

`ifdef BMP_PIXEL_READER_PAD_EN
  // Rows start on 4-byte boundaries; the row-end step jumps over the pad.
  localparam int PAD_BYTES = (4 - ((COLS * 3) % 4)) % 4;
  localparam logic [ADDR_BITS-1:0] ROW_END_STEP = ADDR_BITS'(1 + PAD_BYTES);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 rd_en_q;
  logic [1:0]           phase_q;
  logic [COL_BITS-1:0]  col_q;
  logic [ROW_BITS-1:0]  row_q;
  logic                 busy_q;
  logic                 frame_done_q;

  logic                 rd_valid_q;
  logic [1:0]           rd_phase_q;
  logic [WIDTH-1:0]     b_stage_q;
  logic [WIDTH-1:0]     g_stage_q;
  logic [WIDTH-1:0]     r_out_q;
  logic [WIDTH-1:0]     g_out_q;
  logic [WIDTH-1:0]     b_out_q;
  logic                 done_q;

  // Read sequencer: walks phase/column/row counters and issues one byte read
  // per cycle. The row-end address step happens in the same cycle as the
  // column wrap so the read stream never stalls. After the final R byte is
  // issued the reader drains until that byte has come back and been strobed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      phase_q      <= PHASE_B;
      col_q        <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // busy stays high through the frame_done cycle and falls one
          // cycle later unless a new frame is started right away.
          busy_q <= bus.start;
          if (bus.start) begin
            state_q <= READ;
            addr_q  <= bus.pix_base;
            rd_en_q <= 1'b1;
            phase_q <= PHASE_B;
            col_q   <= '0;
            row_q   <= '0;
          end
        end

        READ: begin
          if (phase_q != PHASE_R) begin
            phase_q <= phase_q + 2'd1;
            addr_q  <= addr_q + ADDR_ONE;
          end else begin
            phase_q <= PHASE_B;
            if (col_q != LAST_COL) begin
              col_q  <= col_q + COL_ONE;
              addr_q <= addr_q + ADDR_ONE;
            end else begin
              col_q <= '0;
              if (row_q == LAST_ROW) begin
                // Last byte of the frame was just issued.
                state_q <= DRAIN;
                rd_en_q <= 1'b0;
              end else begin
                row_q <= row_q + ROW_ONE;
`ifdef BMP_PIXEL_READER_PAD_EN
                addr_q <= addr_q + ROW_END_STEP;
`else
                addr_q <= addr_q + ADDR_ONE;
`endif
              end
            end
          end
        end

        DRAIN: begin
          // The final R byte returns now; the capture pipeline strobes the
          // last pixel at this same edge, so frame_done lines up with it.
          if (rd_valid_q && (rd_phase_q == PHASE_R)) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture pipeline: each returning byte is tagged with the phase it was
  // read in, one cycle late to match the memory latency. B and G wait in
  // staging registers so all three channels update together on the R byte,
  // and the outputs hold their value between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_phase_q <= PHASE_B;
      b_stage_q  <= '0;
      g_stage_q  <= '0;
      r_out_q    <= '0;
      g_out_q    <= '0;
      b_out_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_q;
      rd_phase_q <= phase_q;
      done_q     <= 1'b0;
      if (rd_valid_q) begin
        case (rd_phase_q)
          PHASE_B: b_stage_q <= bus.mem_rd_data;
          PHASE_G: g_stage_q <= bus.mem_rd_data;
          PHASE_R: begin
            r_out_q <= bus.mem_rd_data;
            g_out_q <= g_stage_q;
            b_out_q <= b_stage_q;
            done_q  <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.mem_addr      = addr_q;
  assign bus.mem_rd_en     = rd_en_q;
  assign bus.r_data_out    = r_out_q;
  assign bus.g_data_out    = g_out_q;
  assign bus.b_data_out    = b_out_q;
  assign bus.data_out_done = done_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = frame_done_q;

endmodule

// File: tb/tb_bmp_pixel_reader.sv
// tb_bmp_pixel_reader
// Directed bench for bmp_pixel_reader. Two instances share clock and reset:
//   dut_a  COLS=4, ROWS=2 (12-byte rows, never padded)
//   dut_b  COLS=3, ROWS=2 (9-byte rows, padded to 12 when
//          BMP_PIXEL_READER_PAD_EN is defined)
// Each has a byte memory model whose byte k holds k[7:0], returned the cycle
// after the read enable.
module tb_bmp_pixel_reader;

  localparam int WIDTH     = 8;
  localparam int ADDR_BITS = 20;

`ifdef BMP_PIXEL_READER_PAD_EN
  localparam int B_PAD = 3;
`else
  localparam int B_PAD = 0;
`endif

  logic clk;
  logic reset;

  int tests_run    = 0;
  int tests_failed = 0;

  int strobes_a = 0;
  int strobes_b = 0;
  int addr_q_a[$];
  int addr_q_b[$];

  bmp_pixel_reader_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus_a ();
  bmp_pixel_reader_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus_b ();

  bmp_pixel_reader #(.WIDTH(WIDTH), .ROWS(2), .COLS(4), .ADDR_BITS(ADDR_BITS)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.master)
  );

  bmp_pixel_reader #(.WIDTH(WIDTH), .ROWS(2), .COLS(3), .ADDR_BITS(ADDR_BITS)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memories (byte k = k[7:0]) plus read-address and strobe monitors.
  always @(posedge clk) begin
    if (bus_a.mem_rd_en) begin
      bus_a.mem_rd_data <= bus_a.mem_addr[7:0];
      addr_q_a.push_back(int'(bus_a.mem_addr));
    end
    if (bus_b.mem_rd_en) begin
      bus_b.mem_rd_data <= bus_b.mem_addr[7:0];
      addr_q_b.push_back(int'(bus_b.mem_addr));
    end
    if (bus_a.data_out_done) strobes_a++;
    if (bus_b.data_out_done) strobes_b++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input bit sel_b, input logic [ADDR_BITS-1:0] base);
    if (sel_b) begin
      bus_b.pix_base = base;
      bus_b.start    = 1'b1;
    end else begin
      bus_a.pix_base = base;
      bus_a.start    = 1'b1;
    end
  endtask

  // Steps until frame_done is seen (or the budget runs out, which fails).
  task automatic wait_frame_done(input bit sel_b, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      seen = sel_b ? bus_b.frame_done : bus_a.frame_done;
    end
    check_output(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int s_base;
    int q_base;

    reset = 1'b1;
    bus_a.start = 1'b0;
    bus_a.pix_base = '0;
    bus_b.start = 1'b0;
    bus_b.pix_base = '0;
    step(2);

    // Reset state.
    check_output("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    check_output("rst_rd_en", 32'(bus_a.mem_rd_en), 32'd0);
    check_output("rst_done", 32'(bus_a.data_out_done), 32'd0);
    check_output("rst_busy", 32'(bus_a.busy), 32'd0);
    check_output("rst_frame_done", 32'(bus_a.frame_done), 32'd0);
    check_output("rst_r", 32'(bus_a.r_data_out), 32'd0);
    reset = 1'b0;
    step(2);

    // Frame on dut_a with a stray start pulse during READ.
    $display("[TB] frame A, pix_base=54, stray start in READ");
    s_base = strobes_a;
    q_base = addr_q_a.size();
    apply_stimulus(1'b0, 20'd54);
    step(1);
    bus_a.start = 1'b0;
    check_output("a_c1_busy", 32'(bus_a.busy), 32'd1);
    check_output("a_c1_addr", 32'(bus_a.mem_addr), 32'd54);
    check_output("a_c1_rd_en", 32'(bus_a.mem_rd_en), 32'd1);
    step(3);
    check_output("a_c4_done", 32'(bus_a.data_out_done), 32'd0);
    step(1);
    for (int n = 0; n < 8; n++) begin
      check_output("a_pix_done", 32'(bus_a.data_out_done), 32'd1);
      check_output("a_pix_b", 32'(bus_a.b_data_out), 32'(54 + 3 * n));
      check_output("a_pix_g", 32'(bus_a.g_data_out), 32'(55 + 3 * n));
      check_output("a_pix_r", 32'(bus_a.r_data_out), 32'(56 + 3 * n));
      check_output("a_pix_frame_done", 32'(bus_a.frame_done), 32'(n == 7));
      if (n < 7) begin
        step(1);
        check_output("a_gap_done", 32'(bus_a.data_out_done), 32'd0);
        if (n == 1) bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        step(1);
      end
    end
    step(1);
    check_output("a_end_busy", 32'(bus_a.busy), 32'd0);
    check_output("a_end_frame_done", 32'(bus_a.frame_done), 32'd0);
    check_output("a_end_rd_en", 32'(bus_a.mem_rd_en), 32'd0);
    step(5);
    check_output("a_strobe_count", 32'(strobes_a - s_base), 32'd8);
    check_output("a_read_count", 32'(addr_q_a.size() - q_base), 32'd24);
    for (int i = 0; i < 24 && (q_base + i) < addr_q_a.size(); i++)
      check_output("a_read_addr", 32'(addr_q_a[q_base + i]), 32'(54 + i));

    // start held high: next frame begins the cycle after frame_done.
    $display("[TB] frame A back-to-back, start held high");
    s_base = strobes_a;
    apply_stimulus(1'b0, 20'd54);
    step(26);
    check_output("bb_frame_done", 32'(bus_a.frame_done), 32'd1);
    check_output("bb_last_r", 32'(bus_a.r_data_out), 32'd77);
    step(1);
    check_output("bb_restart_addr", 32'(bus_a.mem_addr), 32'd54);
    check_output("bb_restart_rd_en", 32'(bus_a.mem_rd_en), 32'd1);
    check_output("bb_restart_busy", 32'(bus_a.busy), 32'd1);
    step(4);
    check_output("bb_first_done", 32'(bus_a.data_out_done), 32'd1);
    check_output("bb_first_b", 32'(bus_a.b_data_out), 32'd54);
    bus_a.start = 1'b0;
    wait_frame_done(1'b0, 60, "bb_frame2_timeout");
    step(3);
    check_output("bb_strobe_count", 32'(strobes_a - s_base), 32'd16);

    // Asynchronous reset after five pixels, then restart.
    $display("[TB] frame A aborted by reset after 5 pixels");
    s_base = strobes_a;
    apply_stimulus(1'b0, 20'd54);
    step(1);
    bus_a.start = 1'b0;
    step(16);
    check_output("ab_pix5_done", 32'(bus_a.data_out_done), 32'd1);
    check_output("ab_pix5_b", 32'(bus_a.b_data_out), 32'd66);
    step(1);
    #3;
    reset = 1'b1;
    #1;
    check_output("ab_rst_addr", 32'(bus_a.mem_addr), 32'd0);
    check_output("ab_rst_rd_en", 32'(bus_a.mem_rd_en), 32'd0);
    check_output("ab_rst_r", 32'(bus_a.r_data_out), 32'd0);
    check_output("ab_rst_g", 32'(bus_a.g_data_out), 32'd0);
    check_output("ab_rst_b", 32'(bus_a.b_data_out), 32'd0);
    check_output("ab_rst_busy", 32'(bus_a.busy), 32'd0);
    #1;
    reset = 1'b0;
    step(12);
    check_output("ab_no_strobe", 32'(strobes_a - s_base), 32'd5);
    check_output("ab_idle_busy", 32'(bus_a.busy), 32'd0);
    apply_stimulus(1'b0, 20'd54);
    step(1);
    bus_a.start = 1'b0;
    check_output("ab_re_addr", 32'(bus_a.mem_addr), 32'd54);
    step(4);
    check_output("ab_re_done", 32'(bus_a.data_out_done), 32'd1);
    check_output("ab_re_r", 32'(bus_a.r_data_out), 32'd56);
    check_output("ab_re_g", 32'(bus_a.g_data_out), 32'd55);
    check_output("ab_re_b", 32'(bus_a.b_data_out), 32'd54);
    wait_frame_done(1'b0, 60, "ab_frame_timeout");

    // dut_b: 9-byte rows, padded to 12 only with the pad macro.
    $display("[TB] frame B, COLS=3, pad=%0d", B_PAD);
    s_base = strobes_b;
    q_base = addr_q_b.size();
    apply_stimulus(1'b1, 20'd0);
    step(1);
    bus_b.start = 1'b0;
    wait_frame_done(1'b1, 60, "b_frame_timeout");
    check_output("b_last_b", 32'(bus_b.b_data_out), 32'(15 + B_PAD));
    check_output("b_last_g", 32'(bus_b.g_data_out), 32'(16 + B_PAD));
    check_output("b_last_r", 32'(bus_b.r_data_out), 32'(17 + B_PAD));
    step(3);
    check_output("b_strobe_count", 32'(strobes_b - s_base), 32'd6);
    check_output("b_read_count", 32'(addr_q_b.size() - q_base), 32'd18);
    for (int i = 0; i < 18 && (q_base + i) < addr_q_b.size(); i++)
      check_output("b_read_addr", 32'(addr_q_b[q_base + i]),
                   32'((i < 9) ? i : i + B_PAD));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bmp_pixel_reader.md
# bmp_pixel_reader

Synthesizable pixel source that feeds the sharpening filter. Reads a 24-bit BMP pixel array (B,G,R byte order, bottom-up rows) from a byte-wide synchronous memory and emits one RGB pixel per `data_out_done` strobe on the same `r/g/b` + strobe interface that `filter_mod` consumes on its input. It replaces the behavioural BMP parsing loop with hardware that can sit between frame memory and the filter in the FPGA build.

## Interface
- `WIDTH`, 8, bits per colour channel and per memory byte
- `ROWS`, 512, pixel rows per frame
- `COLS`, 512, pixels per row
- `ADDR_BITS`, 20, memory byte-address width
- `clk`  input  1  system clock
- `reset`  input  1  asynchronous, active-high reset
- `start`  input  1  frame start request, sampled only in IDLE
- `pix_base`  input  ADDR_BITS  byte address of first pixel byte (BMP pixel-array offset), sampled with `start`
- `mem_addr`  output  ADDR_BITS  memory read address
- `mem_rd_en`  output  1  memory read enable
- `mem_rd_data`  input  WIDTH  read data, valid the cycle after `mem_rd_en`
- `r_data_out`, `g_data_out`, `b_data_out`  output  WIDTH each  pixel channels
- `data_out_done`  output  1  one-cycle strobe: pixel channels valid
- `busy`  output  1  frame in progress
- `frame_done`  output  1  one-cycle pulse with last pixel of frame

## Operation
- Only one clock and one reset: `clk`, and `reset`, which is asynchronous and active-high.
- States: IDLE, READ, DRAIN.
- IDLE: `start`=1 latches `pix_base` into address register, clears byte phase (0..2), column (0..COLS-1) and row (0..ROWS-1) counters, goes to READ.
- READ: `mem_rd_en`=1 every cycle, address +1 per cycle; phase cycles B(0), G(1), R(2). After phase 2 of the last column, column wraps to 0, row increments, and address advances by pad bytes (see Configuration) in the same cycle, so there are no bubbles. After the R read of pixel (ROWS-1, COLS-1), go to DRAIN.
- Capture pipeline: returned byte tagged with delayed phase; B and G are held in staging registers. On R return, all three channels load the output registers together, and `data_out_done` is set next cycle.
- DRAIN: `mem_rd_en`=0; wait for the last pixel strobe, then pulse `frame_done` and return to IDLE.
- `start` in READ/DRAIN is ignored.
- Reset values: `mem_addr`=0, `mem_rd_en`=0, all channels 0, `data_out_done`=0, `busy`=0, `frame_done`=0, state IDLE. Reset mid-frame aborts immediately; no further strobes.
- Counters sized with `$clog2`. Address arithmetic is modulo 2^ADDR_BITS (wrap is not flagged).

## Timing
- `start` high in cycle 0 (IDLE) → `busy`=1 and first read (`mem_addr`=`pix_base`) in cycle 1.
- Reads in cycles 1,2,3 (B,G,R); R data in cycle 4; first `data_out_done` in cycle 5.
- Pixel n strobes in cycle 5+3n; steady-state rate is one pixel per 3 cycles. Output channels hold their value between strobes.
- `frame_done` is high in the same cycle as the final `data_out_done` (cycle 5+3(ROWS·COLS−1)). `busy` drops the cycle after.
- `start` asserted in the cycle after `frame_done` is accepted (state is IDLE), so back-to-back frames incur 1 idle cycle.

## Configuration
- `BMP_PIXEL_READER_PAD_EN` defined: row stride is COLS·3 rounded up to a multiple of 4. At each row end, the address skips `(4 − (COLS·3 mod 4)) mod 4` pad bytes. The skip adds no cycles and issues no reads of pad bytes.
- Undefined: rows are tightly packed (stride = COLS·3) and no skip logic is built. Correct only when COLS·3 is a multiple of 4 (the 512-column build).

## Test plan
- Reset asserted asynchronously mid-cycle → all outputs 0 immediately, state IDLE; no strobe after deassert without `start`.
- COLS=4, ROWS=2, `pix_base`=54, memory byte k = k[7:0] → first strobe cycle 5 with r=56,g=55,b=54. Strobes every 3 cycles, 8 total. Last pixel r=77,g=76,b=75 with `frame_done`.
- COLS=3, ROWS=2, macro defined, `pix_base`=0 → row 0 reads addresses 0–8, row 1 reads 12–20 (9–11 never read). Without the macro, row 1 reads 9–17.
- `start` pulsed during READ → ignored; `mem_addr` sequence and strobe count unchanged.
- `reset` asserted after 5 pixels of a 512×512 frame → outputs cleared. A new `start` with `pix_base`=54 restarts at address 54, and the first strobe comes 5 cycles later.
- `start` held high continuously → second frame starts the cycle after `frame_done`. The full 512×512 run produces 262144 strobes per frame at exactly 3-cycle spacing.
